multi_key_interrupt_controller: RTL

Parametrised interrupt source between the board key inputs and the CPU interrupt port. It synchronises `NUM_KEYS` asynchronous key lines, latches each rising edge as a sticky pending request, and generates a programmable-rate frame-ready tick. Pending requests are arbitrated by fixed priority and issued one at a time as 32-bit interrupt instructions. Delivery uses either a valid/ack handshake or a legacy single-cycle pulse.

---
 rtl/multi_key_interrupt_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/multi_key_interrupt_controller.sv
// Key and frame interrupt source: synchronises key lines, latches sticky pending requests,
// and issues them one at a time as 32-bit interrupt instructions by fixed priority.
module multi_key_interrupt_controller #(
   parameter int         NUM_KEYS   = 4,
   parameter int         FRAME_DIV  = 833333,
   parameter int         CNT_W      = 32,
   parameter logic [4:0] INT_OPCODE = 5'b11111,
   parameter bit         PULSE_MODE = 1'b0
) (
   input  logic                proc_clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic [NUM_KEYS-1:0] key_enable,
   input  logic                irq_ack,
   output logic                irq_valid,
   output logic [31:0]         irq_instruction,
   output logic [NUM_KEYS:0]   pending,
   output logic [7:0]          dropped
);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_DIV - 1);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_t;

   state_t state;

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] hist;
   logic [CNT_W-1:0]    count;
   logic                frame_tick;
   logic [NUM_KEYS:0]   set_vec;
   logic [NUM_KEYS:0]   clr_vec;
   logic [NUM_KEYS:0]   drop_vec;
   logic [NUM_KEYS:0]   pending_next;
   logic [4:0]          win_id;
   logic                found;
   logic                grant;
   logic [5:0]          drop_inc;
   logic [8:0]          drop_sum;

   always_ff @(posedge proc_clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= keys;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign frame_tick = (count == FRAME_LAST);

   always_ff @(posedge proc_clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (frame_tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   // Bit 0 is the frame tick; bit i+1 is a qualified rising edge on key i.
   assign set_vec = {sync2 & ~hist & key_enable, frame_tick};

   always_comb begin
      win_id  = '0;
      clr_vec = '0;
      found   = 1'b0;
      for (int i = 0; i <= NUM_KEYS; i++) begin
         if (pending[i] && !found) begin
            found      = 1'b1;
            win_id     = 5'(i);
            clr_vec[i] = (state == IDLE);
         end
      end
   end

   assign grant = found && (state == IDLE);

   // A set landing on a bit being cleared re-queues; a set on a bit still held is a loss.
   assign drop_vec     = set_vec & pending & ~clr_vec;
   assign pending_next = (pending & ~clr_vec) | set_vec;

   always_comb begin
      drop_inc = '0;
      for (int i = 0; i <= NUM_KEYS; i++) begin
         drop_inc = drop_inc + 6'(drop_vec[i]);
      end
   end

   assign drop_sum = {1'b0, dropped} + {3'b000, drop_inc};

   always_ff @(posedge proc_clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
         dropped <= '0;
      end else begin
         pending <= pending_next;
         dropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   always_ff @(posedge proc_clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         irq_valid       <= 1'b0;
         irq_instruction <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  irq_valid       <= 1'b1;
                  irq_instruction <= {INT_OPCODE, 22'b0, win_id};
                  state           <= PRESENT;
               end
            end
            PRESENT: begin
               if (PULSE_MODE || irq_ack) begin
                  irq_valid       <= 1'b0;
                  irq_instruction <= '0;
                  state           <= IDLE;
               end
            end
            default: begin
               irq_valid       <= 1'b0;
               irq_instruction <= '0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule
